tdd_frame_timer: RTL and testbench

TDD_FRAME_TIMER -- requirements
Module: tdd_frame_timer

---
 rtl/tdd_frame_timer.sv | 91 +++++++++
 tb/tb_tdd_frame_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdd_frame_timer.sv
// TDD/FDD frame timer: sample counter with per-frame length, one-shot adjusted frame
// and registered TX/RX window indicators aligned to the counter.
module tdd_frame_timer #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sample_en,
   input  logic             tddmode,
   input  logic [CNT_W-1:0] frame_len,
   input  logic [CNT_W-1:0] frame_adj,
   input  logic             adj_wr,
   input  logic [CNT_W-1:0] tstart,
   input  logic [CNT_W-1:0] tend,
   input  logic [CNT_W-1:0] rstart,
   input  logic [CNT_W-1:0] rend,
   output logic [CNT_W-1:0] cnt,
   output logic             frame_start,
   output logic [31:0]      frame_num,
   output logic             tx_win,
   output logic             rx_win,
   output logic             adj_pending
);

   logic [CNT_W-1:0] cur_len;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] len_d;
   logic [31:0]      num_d;
   logic             start_d;
   logic             pend_d;
   logic             tx_d;
   logic             rx_d;

   function automatic logic [CNT_W-1:0] nonzero(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   // Inclusive window; start > stop means the window wraps through the frame boundary.
   function automatic logic in_win(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] s,
                                   input logic [CNT_W-1:0] e);
      if (s <= e) return (c >= s) && (c <= e);
      else        return (c >= s) || (c <= e);
   endfunction

   always_comb begin
      cnt_d   = cnt;
      len_d   = cur_len;
      num_d   = frame_num;
      start_d = 1'b0;
      pend_d  = adj_pending | adj_wr;
      if (!en) begin
         cnt_d = '0;
         len_d = nonzero(frame_len);
      end else if (sample_en) begin
         if (cnt == cur_len - CNT_W'(1)) begin
            cnt_d   = '0;
            start_d = 1'b1;
            num_d   = frame_num + 32'd1;
            len_d   = adj_pending ? nonzero(frame_adj) : nonzero(frame_len);
            // Wrap consumes the old request; a coincident adj_wr re-arms for the next wrap.
            pend_d  = adj_wr;
         end else begin
            cnt_d = cnt + CNT_W'(1);
         end
      end
      tx_d = en & (~tddmode | in_win(cnt_d, tstart, tend));
      rx_d = en & (~tddmode | in_win(cnt_d, rstart, rend));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         cur_len     <= nonzero(frame_len);
         frame_num   <= '0;
         frame_start <= 1'b0;
         tx_win      <= 1'b0;
         rx_win      <= 1'b0;
         adj_pending <= 1'b0;
      end else begin
         cnt         <= cnt_d;
         cur_len     <= len_d;
         frame_num   <= num_d;
         frame_start <= start_d;
         tx_win      <= tx_d;
         rx_win      <= rx_d;
         adj_pending <= pend_d;
      end
   end

endmodule

// File: tb/tb_tdd_frame_timer.sv
// Directed self-checking bench for tdd_frame_timer.
module tb_tdd_frame_timer;

   logic        clk = 1'b0;
   logic        rst, en, sample_en, tddmode, adj_wr;
   logic [23:0] frame_len, frame_adj, tstart, tend, rstart, rend;
   logic [23:0] cnt;
   logic        frame_start, tx_win, rx_win, adj_pending;
   logic [31:0] frame_num;

   int total  = 0;
   int passed = 0;

   tdd_frame_timer #(.CNT_W(24)) dut (
      .clk(clk), .rst(rst), .en(en), .sample_en(sample_en), .tddmode(tddmode),
      .frame_len(frame_len), .frame_adj(frame_adj), .adj_wr(adj_wr),
      .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
      .cnt(cnt), .frame_start(frame_start), .frame_num(frame_num),
      .tx_win(tx_win), .rx_win(rx_win), .adj_pending(adj_pending)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; sample_en = 1'b1; tddmode = 1'b1; adj_wr = 1'b1;
      frame_len = 24'd8; frame_adj = 24'd5;
      tstart = 24'd2; tend = 24'd4; rstart = 24'd5; rend = 24'd7;
      step();
      step();
      total++;
      if ({cnt, frame_start, frame_num, tx_win, rx_win, adj_pending} !== 60'd0)
         $display("FAIL reset: cnt=%0d fs=%b fn=%0d tx=%b rx=%b pend=%b, want all zero",
                  cnt, frame_start, frame_num, tx_win, rx_win, adj_pending);
      else passed++;
      rst = 1'b0; adj_wr = 1'b0; en = 1'b1;
   endtask

   task automatic test_basic();
      logic [23:0] ec = 24'd0;
      logic [31:0] efn = 32'd0;
      for (int i = 0; i < 17; i++) begin
         step();
         ec = (ec == 24'd7) ? 24'd0 : ec + 24'd1;
         if (ec == 24'd0) efn++;
         total++;
         if ({cnt, frame_start, frame_num, tx_win, rx_win} !==
             {ec, ec == 24'd0, efn, ec >= 24'd2 && ec <= 24'd4, ec >= 24'd5})
            $display("FAIL basic[%0d]: cnt=%0d fs=%b fn=%0d tx=%b rx=%b, want cnt=%0d fn=%0d",
                     i, cnt, frame_start, frame_num, tx_win, rx_win, ec, efn);
         else passed++;
      end
   endtask

   task automatic test_adjust();
      logic [23:0] ec, elen;
      logic        ep;
      for (int i = 0; i < 20 && cnt != 24'd3; i++) step();
      total++;
      if (cnt !== 24'd3) $display("FAIL adjust_sync: cnt=%0d, want 3", cnt);
      else passed++;
      adj_wr = 1'b1; frame_adj = 24'd5;
      step();
      adj_wr = 1'b0;
      ec = 24'd4; elen = 24'd8; ep = 1'b1;
      total++;
      if ({cnt, adj_pending} !== {ec, ep})
         $display("FAIL adjust_set: cnt=%0d pend=%b, want cnt=4 pend=1", cnt, adj_pending);
      else passed++;
      for (int i = 0; i < 18; i++) begin
         step();
         if (ec == elen - 24'd1) begin
            ec = 24'd0; elen = ep ? 24'd5 : 24'd8; ep = 1'b0;
         end else ec = ec + 24'd1;
         total++;
         if ({cnt, adj_pending, frame_start} !== {ec, ep, ec == 24'd0})
            $display("FAIL adjust[%0d]: cnt=%0d pend=%b fs=%b, want cnt=%0d pend=%b",
                     i, cnt, adj_pending, frame_start, ec, ep);
         else passed++;
      end
   endtask

   task automatic test_coincident();
      logic [23:0] ec, elen;
      logic        ep;
      for (int i = 0; i < 20 && cnt != 24'd7; i++) step();
      total++;
      if (cnt !== 24'd7) $display("FAIL coincident_sync: cnt=%0d, want 7", cnt);
      else passed++;
      adj_wr = 1'b1; frame_adj = 24'd3;
      step();
      adj_wr = 1'b0;
      ec = 24'd0; elen = 24'd8; ep = 1'b1;
      total++;
      if ({cnt, adj_pending, frame_start} !== {ec, ep, 1'b1})
         $display("FAIL coincident_wrap: cnt=%0d pend=%b fs=%b, want cnt=0 pend=1 fs=1",
                  cnt, adj_pending, frame_start);
      else passed++;
      for (int i = 0; i < 13; i++) begin
         step();
         if (ec == elen - 24'd1) begin
            ec = 24'd0; elen = ep ? 24'd3 : 24'd8; ep = 1'b0;
         end else ec = ec + 24'd1;
         total++;
         if ({cnt, adj_pending} !== {ec, ep})
            $display("FAIL coincident[%0d]: cnt=%0d pend=%b, want cnt=%0d pend=%b",
                     i, cnt, adj_pending, ec, ep);
         else passed++;
      end
   endtask

   task automatic test_wrap_fdd();
      logic [23:0] ec;
      for (int i = 0; i < 20 && cnt != 24'd7; i++) step();
      total++;
      if (cnt !== 24'd7) $display("FAIL wrapwin_sync: cnt=%0d, want 7", cnt);
      else passed++;
      tstart = 24'd6; tend = 24'd1;
      ec = 24'd7;
      for (int i = 0; i < 8; i++) begin
         step();
         ec = (ec == 24'd7) ? 24'd0 : ec + 24'd1;
         total++;
         if ({cnt, tx_win, rx_win} !== {ec, ec >= 24'd6 || ec <= 24'd1, ec >= 24'd5})
            $display("FAIL wrapwin[%0d]: cnt=%0d tx=%b rx=%b, want cnt=%0d", i, cnt,
                     tx_win, rx_win, ec);
         else passed++;
      end
      tddmode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         total++;
         if ({tx_win, rx_win} !== 2'b11)
            $display("FAIL fdd[%0d]: cnt=%0d tx=%b rx=%b, want tx=1 rx=1", i, cnt, tx_win,
                     rx_win);
         else passed++;
      end
   endtask

   task automatic test_strobe_en_reset();
      logic [23:0] ec = 24'd0;
      logic [31:0] efn = 32'd0;
      logic        stb;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 27; k++) begin
         stb = (k % 3 == 0);
         sample_en = stb;
         step();
         if (stb) begin
            ec = (ec == 24'd7) ? 24'd0 : ec + 24'd1;
            if (ec == 24'd0) efn++;
         end
         total++;
         if ({cnt, frame_start, frame_num, tx_win} !== {ec, stb && ec == 24'd0, efn, 1'b1})
            $display("FAIL strobe[%0d]: cnt=%0d fs=%b fn=%0d tx=%b, want cnt=%0d fn=%0d",
                     k, cnt, frame_start, frame_num, tx_win, ec, efn);
         else passed++;
      end
      en = 1'b0; sample_en = 1'b1; adj_wr = 1'b1;
      step();
      adj_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({cnt, tx_win, rx_win, frame_start, frame_num, adj_pending} !==
             {24'd0, 3'b000, efn, 1'b1})
            $display("FAIL en_off[%0d]: cnt=%0d tx=%b rx=%b fs=%b fn=%0d pend=%b, want fn=%0d",
                     i, cnt, tx_win, rx_win, frame_start, frame_num, adj_pending, efn);
         else passed++;
         step();
      end
      en = 1'b1; tddmode = 1'b1; tstart = 24'd2; tend = 24'd4;
      for (int i = 0; i < 20 && cnt != 24'd5; i++) step();
      total++;
      if ({cnt, tx_win, rx_win} !== {24'd5, 1'b0, 1'b1})
         $display("FAIL reset_sync: cnt=%0d tx=%b rx=%b, want cnt=5 tx=0 rx=1", cnt,
                  tx_win, rx_win);
      else passed++;
      rst = 1'b1; adj_wr = 1'b1;
      step();
      rst = 1'b0; adj_wr = 1'b0;
      total++;
      if ({cnt, frame_start, frame_num, tx_win, rx_win, adj_pending} !== 60'd0)
         $display("FAIL midframe_reset: cnt=%0d fs=%b fn=%0d tx=%b rx=%b pend=%b, want zero",
                  cnt, frame_start, frame_num, tx_win, rx_win, adj_pending);
      else passed++;
   endtask

   task automatic test_degenerate();
      frame_len = 24'd0; rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         total++;
         if ({cnt, frame_start, frame_num} !== {24'd0, 1'b1, 32'(i)})
            $display("FAIL degenerate[%0d]: cnt=%0d fs=%b fn=%0d, want cnt=0 fs=1 fn=%0d",
                     i, cnt, frame_start, frame_num, i);
         else passed++;
      end
      sample_en = 1'b0;
      step();
      total++;
      if ({cnt, frame_start, frame_num} !== {24'd0, 1'b0, 32'd5})
         $display("FAIL degenerate_hold: cnt=%0d fs=%b fn=%0d, want cnt=0 fs=0 fn=5",
                  cnt, frame_start, frame_num);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_adjust();
      test_coincident();
      test_wrap_fdd();
      test_strobe_en_reset();
      test_degenerate();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
